instr_encoder: RTL and testbench

- Inverse of the opcode/type decoder: builds 32-bit RV32I instruction words from a type tag plus register, function and immediate fields.
- Buffers encoded words in a small FIFO and emits them as an addressed write stream, for example an instruction-memory loader or a bench program generator.
- Sits in front of the instruction memory write port. Valid/ready on both sides.

---
 rtl/instr_enc_pkg.sv | 45 ++++
 rtl/instr_fmt_encode.sv | 51 +++++
 rtl/instr_encoder.sv | 106 ++++++++++
 tb/tb_instr_encoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types for the RV32I instruction encoder: type tags, opcodes and the field bundle.
// Optional immediate range checking is enabled with INSTR_ENC_RANGE_CHECK_EN.
package instr_enc_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [3:0] {
    R       = 4'd0,
    I_LOAD  = 4'd1,
    I_ALU   = 4'd2,
    I_JALR  = 4'd3,
    S       = 4'd4,
    SB      = 4'd5,
    U_AUIPC = 4'd6,
    U_LUI   = 4'd7,
    UJ      = 4'd8
  } instr_type_e;

  localparam logic [6:0] OP_R       = 7'h33;
  localparam logic [6:0] OP_I_LOAD  = 7'h03;
  localparam logic [6:0] OP_I_ALU   = 7'h13;
  localparam logic [6:0] OP_I_JALR  = 7'h67;
  localparam logic [6:0] OP_S       = 7'h23;
  localparam logic [6:0] OP_SB      = 7'h63;
  localparam logic [6:0] OP_U_AUIPC = 7'h17;
  localparam logic [6:0] OP_U_LUI   = 7'h37;
  localparam logic [6:0] OP_UJ      = 7'h6F;

  typedef struct packed {
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm;
  } instr_fields_t;

  // True when v is the sign extension of its low w bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic [31:0] t;
    t = 32'($signed(v) >>> (w - 1));
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_fmt_encode.sv
// Combinational RV32I word builder: packs fields by format and flags unknown tags.
// With INSTR_ENC_RANGE_CHECK_EN defined it also flags unrepresentable immediates.
module instr_fmt_encode
  import instr_enc_pkg::*;
(
  input  logic [3:0]    i_type,
  input  instr_fields_t i_fields,
  output logic [31:0]   o_instr_c,
  output logic          o_illegal_c,
  output logic          o_range_err_c
);

  logic [31:0] w_imm;
  assign w_imm = i_fields.imm;

  always_comb begin
    o_instr_c   = '0;
    o_illegal_c = 1'b0;
    case (i_type)
      R:       o_instr_c = {i_fields.funct7, i_fields.rs2, i_fields.rs1, i_fields.funct3,
                            i_fields.rd, OP_R};
      I_LOAD:  o_instr_c = {w_imm[11:0], i_fields.rs1, i_fields.funct3, i_fields.rd, OP_I_LOAD};
      I_ALU:   o_instr_c = {w_imm[11:0], i_fields.rs1, i_fields.funct3, i_fields.rd, OP_I_ALU};
      I_JALR:  o_instr_c = {w_imm[11:0], i_fields.rs1, 3'b000, i_fields.rd, OP_I_JALR};
      S:       o_instr_c = {w_imm[11:5], i_fields.rs2, i_fields.rs1, i_fields.funct3,
                            w_imm[4:0], OP_S};
      SB:      o_instr_c = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1,
                            i_fields.funct3, w_imm[4:1], w_imm[11], OP_SB};
      U_AUIPC: o_instr_c = {w_imm[31:12], i_fields.rd, OP_U_AUIPC};
      U_LUI:   o_instr_c = {w_imm[31:12], i_fields.rd, OP_U_LUI};
      UJ:      o_instr_c = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_fields.rd, OP_UJ};
      default: o_illegal_c = 1'b1;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  always_comb begin
    o_range_err_c = 1'b0;
    case (i_type)
      I_LOAD, I_ALU, I_JALR, S: o_range_err_c = !fits_signed(w_imm, 12);
      SB:                       o_range_err_c = !fits_signed(w_imm, 13) || w_imm[0];
      UJ:                       o_range_err_c = !fits_signed(w_imm, 21) || w_imm[0];
      U_AUIPC, U_LUI:           o_range_err_c = (w_imm[11:0] != 12'd0);
      default:                  o_range_err_c = 1'b0;
    endcase
  end
`else
  assign o_range_err_c = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding an addressed write stream through a small FIFO.
// Optional immediate range checking: define INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned       DEPTH      = 4,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_type,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     err_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  instr_fields_t     w_fields;
  logic [31:0]       w_instr;
  logic              w_illegal;
  logic              w_range_err;
  logic              w_in_hs;
  logic              w_push;
  logic              w_pop;

  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_last;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  always_comb begin
    w_fields.funct7 = in_funct7;
    w_fields.rs2    = in_rs2;
    w_fields.rs1    = in_rs1;
    w_fields.funct3 = in_funct3;
    w_fields.rd     = in_rd;
    w_fields.imm    = in_imm;
  end

  instr_fmt_encode u_fmt_encode (
    .i_type        (in_type),
    .i_fields      (w_fields),
    .o_instr_c     (w_instr),
    .o_illegal_c   (w_illegal),
    .o_range_err_c (w_range_err)
  );

  // Rejected requests still complete the handshake; they just never reach the FIFO.
  assign in_ready = (r_count < CNT_W'(DEPTH));
  assign w_in_hs  = in_valid && in_ready;
  assign w_push   = w_in_hs && !w_illegal && !w_range_err;
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
      r_addr   <= START_ADDR;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
        r_addr   <= r_addr + ADDR_W'(4);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_err <= w_in_hs && (w_illegal || w_range_err);
    end
  end

  // With the FIFO empty the last emitted word stays visible.
  assign out_valid   = (r_count != '0);
  assign out_instr   = out_valid ? r_mem[r_rd_ptr] : r_last;
  assign out_addr    = r_addr;
  assign err_illegal = r_err;
  assign count       = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4, START_ADDR=0).
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_type;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic [2:0]        count;

  int n_checks = 0;
  int n_pass   = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .START_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err_illegal(err_illegal), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, output bit ok);
    int n;
    @(negedge clk);
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one(output logic [31:0] instr, output logic [ADDR_W-1:0] addr,
                         output bit ok);
    int n;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    instr = out_instr;
    addr = out_addr;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h want 0", out_instr); else n_pass++;
    n_checks++; if (out_addr !== 32'h0) $display("FAIL reset_out_addr: got %h want 0", out_addr); else n_pass++;
    n_checks++; if (err_illegal !== 1'b0) $display("FAIL reset_err: got %b want 0", err_illegal); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_i_alu();
    bit ok;
    do_reset();
    out_ready = 1'b1;
    push(I_ALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, ok);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL ialu_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_instr !== 32'h00500093) $display("FAIL ialu_instr: got %h want 00500093", out_instr); else n_pass++;
    n_checks++; if (out_addr !== 32'h0) $display("FAIL ialu_addr: got %h want 0", out_addr); else n_pass++;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) $display("FAIL ialu_count_after_pop: got %0d want 0", count); else n_pass++;
    n_checks++; if (out_addr !== 32'h4) $display("FAIL ialu_addr_after_pop: got %h want 4", out_addr); else n_pass++;
    n_checks++; if (out_instr !== 32'h00500093) $display("FAIL ialu_hold_last: got %h want 00500093", out_instr); else n_pass++;
  endtask

  task automatic test_r_s();
    bit ok;
    logic [31:0] w;
    logic [ADDR_W-1:0] a;
    do_reset();
    out_ready = 1'b0;
    push(R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, ok);
    push(S, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8, ok);
    pop_one(w, a, ok);
    n_checks++; if (!ok || w !== 32'h002081B3) $display("FAIL r_instr: got %h want 002081B3", w); else n_pass++;
    n_checks++; if (!ok || a !== 32'h0) $display("FAIL r_addr: got %h want 0", a); else n_pass++;
    pop_one(w, a, ok);
    n_checks++; if (!ok || w !== 32'h0020A423) $display("FAIL s_instr: got %h want 0020A423", w); else n_pass++;
    n_checks++; if (!ok || a !== 32'h4) $display("FAIL s_addr: got %h want 4", a); else n_pass++;
  endtask

  task automatic test_u_uj_sb();
    bit ok;
    logic [31:0] w;
    logic [ADDR_W-1:0] a;
    do_reset();
    out_ready = 1'b0;
    push(U_LUI, 5'd5, 5'd7, 5'd9, 3'd7, 7'd0, 32'h12345000, ok);
    push(UJ, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, ok);
    push(SB, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, ok);
    pop_one(w, a, ok);
    n_checks++; if (!ok || w !== 32'h123452B7) $display("FAIL lui_instr: got %h want 123452B7", w); else n_pass++;
    n_checks++; if (!ok || a !== 32'h0) $display("FAIL lui_addr: got %h want 0", a); else n_pass++;
    pop_one(w, a, ok);
    n_checks++; if (!ok || w !== 32'h008000EF) $display("FAIL uj_instr: got %h want 008000EF", w); else n_pass++;
    n_checks++; if (!ok || a !== 32'h4) $display("FAIL uj_addr: got %h want 4", a); else n_pass++;
    pop_one(w, a, ok);
    n_checks++; if (!ok || w !== 32'hFE000EE3) $display("FAIL sb_instr: got %h want FE000EE3", w); else n_pass++;
    n_checks++; if (!ok || a !== 32'h8) $display("FAIL sb_addr: got %h want 8", a); else n_pass++;
  endtask

  task automatic test_full();
    bit ok;
    int accept_cyc;
    logic [31:0] exp_w [5];
    logic [31:0] exp_a [5];
    logic [31:0] got_w [$];
    logic [31:0] got_a [$];
    exp_w = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(I_ALU, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1), ok);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else n_pass++;
    in_type = I_ALU; in_rd = 5'd5; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd5; in_valid = 1'b1;
    out_ready = 1'b1;
    accept_cyc = -1;
    for (int cyc = 0; cyc < 20 && got_w.size() < 5; cyc++) begin
      if (out_valid) begin
        got_w.push_back(out_instr);
        got_a.push_back(out_addr);
      end
      if (in_valid && in_ready && accept_cyc < 0) accept_cyc = cyc;
      @(posedge clk);
      #1;
      if (accept_cyc >= 0) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (accept_cyc !== 1) $display("FAIL full_accept_cycle: got %0d want 1", accept_cyc); else n_pass++;
    n_checks++; if (got_w.size() !== 5) $display("FAIL full_pop_count: got %0d want 5", got_w.size()); else n_pass++;
    for (int i = 0; i < 5 && i < got_w.size(); i++) begin
      n_checks++; if (got_w[i] !== exp_w[i]) $display("FAIL full_instr_%0d: got %h want %h", i, got_w[i], exp_w[i]); else n_pass++;
      n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL full_addr_%0d: got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    bit ok;
    out_ready = 1'b0;
    push(4'hF, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd4, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL illegal_handshake: in_ready got %b want 1", ok); else n_pass++;
    n_checks++; if (err_illegal !== 1'b1) $display("FAIL illegal_err_pulse: got %b want 1", err_illegal); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL illegal_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL illegal_out_valid: got %b want 0", out_valid); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (err_illegal !== 1'b0) $display("FAIL illegal_err_clear: got %b want 0", err_illegal); else n_pass++;
  endtask

  task automatic test_range();
    bit ok;
    logic [31:0] w;
    logic [ADDR_W-1:0] a;
    out_ready = 1'b0;
    push(I_ALU, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, ok);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    n_checks++; if (err_illegal !== 1'b1) $display("FAIL range_err_pulse: got %b want 1", err_illegal); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL range_dropped_count: got %0d want 0", count); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (err_illegal !== 1'b0) $display("FAIL range_err_clear: got %b want 0", err_illegal); else n_pass++;
`else
    n_checks++; if (err_illegal !== 1'b0) $display("FAIL range_no_err: got %b want 0", err_illegal); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL range_pushed_count: got %0d want 1", count); else n_pass++;
    pop_one(w, a, ok);
    n_checks++; if (!ok || w !== 32'h80000013) $display("FAIL range_trunc_instr: got %h want 80000013", w); else n_pass++;
    n_checks++; if (!ok || a !== 32'h14) $display("FAIL range_trunc_addr: got %h want 14", a); else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(I_LOAD, 5'(i + 2), 5'd1, 5'd0, 3'd2, 7'd0, 32'(4 * i), ok);
    @(negedge clk);
    n_checks++; if (count !== 3'd3) $display("FAIL areset_pre_count: got %0d want 3", count); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) $display("FAIL areset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_addr !== 32'h0) $display("FAIL areset_out_addr: got %h want 0", out_addr); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_stays_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_type = 4'd0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    test_reset();
    test_i_alu();
    test_r_s();
    test_u_uj_sb();
    test_full();
    test_illegal();
    test_range();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
